// File: rtl/serial_tx_queue_if.sv
// Bundle of the NIOS-side write port, transmitter handshake and queue status for serial_tx_queue.
// The ovfCnt member exists only when SERIAL_TXQ_OVF_CNT_EN is defined.
interface serial_tx_queue_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [7:0]      wrData;
  logic            wrEn;
  logic            charSent;
  logic [7:0]      dataToSent;
  logic            transEnable;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            busy;
  logic            txErr;
`ifdef SERIAL_TXQ_OVF_CNT_EN
  logic [7:0]      ovfCnt;
`endif

  modport master (
`ifdef SERIAL_TXQ_OVF_CNT_EN
    input  ovfCnt,
`endif
    output wrData, wrEn, charSent,
    input  dataToSent, transEnable, full, empty, count, busy, txErr
  );

  modport slave (
`ifdef SERIAL_TXQ_OVF_CNT_EN
    output ovfCnt,
`endif
    input  wrData, wrEn, charSent,
    output dataToSent, transEnable, full, empty, count, busy, txErr
  );
endinterface

// File: rtl/serial_tx_queue.sv
// Byte FIFO plus sequencer feeding the serial transmitter; one byte per transEnable burst.
// Optional SERIAL_TXQ_OVF_CNT_EN adds a saturating dropped-write counter (ovfCnt).
module serial_tx_queue #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned TIMEOUT     = 4096
) (
  input logic                clk9600x16,
  input logic                rst,
  serial_tx_queue_if.slave   txq_io
);

  localparam int unsigned CntW  = ADDR_W + 1;
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StGap} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [ToW-1:0]    to_q, to_d;
  logic [7:0]        data_q, data_d;
  logic              txerr_q, txerr_d;
  logic              sync1_q, sync2_q, prev_q;
  logic              done_rise, wr_accept, pop;
  logic              trans_en, busy;

  assign wr_accept = txq_io.wrEn & ~full_q;
  assign done_rise = sync2_q & ~prev_q;

  // Storage needs no reset; only pointers and count define what is valid.
  always_ff @(posedge clk9600x16) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= txq_io.wrData;
    end
  end

  always_comb begin
    wr_ptr_d = wr_accept ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_accept, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CntW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk9600x16 or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      sync1_q  <= txq_io.charSent;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
    end
  end

  // State register
  always_ff @(posedge clk9600x16 or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      hold_q  <= '0;
      to_q    <= '0;
      data_q  <= '0;
      txerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
      data_q  <= data_d;
      txerr_q <= txerr_d;
    end
  end

  // Next-state logic; completion edges are only honoured in StWait.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    to_d    = to_q;
    data_d  = data_q;
    txerr_d = txerr_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty_q) begin
          data_d  = mem_q[rd_ptr_q];
          pop     = 1'b1;
          hold_d  = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
          to_d    = '0;
          state_d = StWait;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StWait: begin
        if (done_rise) begin
          state_d = StGap;
        end else if (to_q == ToW'(TIMEOUT - 1)) begin
          txerr_d = 1'b1;
          state_d = StGap;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state so reset drops transEnable immediately.
  always_comb begin
    trans_en = (state_q == StLoad);
    busy     = (state_q != StIdle);
  end

  assign txq_io.dataToSent  = data_q;
  assign txq_io.transEnable = trans_en;
  assign txq_io.full        = full_q;
  assign txq_io.empty       = empty_q;
  assign txq_io.count       = count_q;
  assign txq_io.busy        = busy;
  assign txq_io.txErr       = txerr_q;

`ifdef SERIAL_TXQ_OVF_CNT_EN
  logic [7:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (txq_io.wrEn && full_q && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_ff @(posedge clk9600x16 or negedge rst) begin
    if (!rst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign txq_io.ovfCnt = ovf_q;
`endif

endmodule

// File: tb/tb_serial_tx_queue.sv
// Directed bench for serial_tx_queue: single byte, full/drop, wrap, timeout, held charSent, reset.
module tb_serial_tx_queue;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned HOLD    = 16;
  localparam int unsigned TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_tx_queue_if #(.ADDR_W(ADDR_W)) bus ();

  serial_tx_queue #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .HOLD_CYCLES (HOLD),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk9600x16 (clk),
    .rst        (rst_n),
    .txq_io     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    bus.wrData = b;
    bus.wrEn   = 1'b1;
    tick();
    bus.wrEn   = 1'b0;
  endtask

  task automatic wait_te(input logic val, input string tag);
    int n = 0;
    while (bus.transEnable !== val && n < 64) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.transEnable), 32'(val));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 10000) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.busy), 32'd0);
  endtask

  task automatic ack(input string tag);
    wait_te(1'b0, "ack_te_low");
    bus.charSent = 1'b1;
    repeat (3) tick();
    bus.charSent = 1'b0;
    wait_idle(tag);
  endtask

  task automatic serve(input logic [7:0] exp, input string tag);
    wait_te(1'b1, "serve_te_high");
    check(tag, 32'(bus.dataToSent), 32'(exp));
    ack("serve_done");
  endtask

  logic [7:0] q [$];
  logic [7:0] b, e;
  int n, nw;

  initial begin
    bus.wrData   = 8'h00;
    bus.wrEn     = 1'b0;
    bus.charSent = 1'b0;
    repeat (3) tick();
    check("rst_data", 32'(bus.dataToSent), 32'h0);
    check("rst_te", 32'(bus.transEnable), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_txerr", 32'(bus.txErr), 32'd0);
`ifdef SERIAL_TXQ_OVF_CNT_EN
    check("rst_ovf", 32'(bus.ovfCnt), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Single byte, charSent 200 cycles after LOAD ends.
    wr(8'h41);
    check("t1_empty_wr", 32'(bus.empty), 32'd0);
    check("t1_te_lat", 32'(bus.transEnable), 32'd0);
    tick();
    check("t1_te_on", 32'(bus.transEnable), 32'd1);
    check("t1_data", 32'(bus.dataToSent), 32'h41);
    check("t1_busy", 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.transEnable && n < 100) begin
      tick();
      n++;
    end
    check("t1_hold_len", 32'(n), 32'(HOLD));
    repeat (200) tick();
    check("t1_wait_busy", 32'(bus.busy), 32'd1);
    check("t1_wait_data", 32'(bus.dataToSent), 32'h41);
    bus.charSent = 1'b1;
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
      if (n == 3) bus.charSent = 1'b0;
    end
    check("t1_busy_fall", 32'(n), 32'd4);
    check("t1_empty_end", 32'(bus.empty), 32'd1);
    check("t1_txerr", 32'(bus.txErr), 32'd0);

    // Fill while a byte is in flight, then drop one write.
    wr(8'hA5);
    tick();
    for (int i = 0; i < 16; i++) wr(8'(i));
    check("t2_count16", 32'(bus.count), 32'd16);
    check("t2_full", 32'(bus.full), 32'd1);
    check("t2_empty", 32'(bus.empty), 32'd0);
    wr(8'hFF);
    check("t2_drop_count", 32'(bus.count), 32'd16);
    check("t2_drop_full", 32'(bus.full), 32'd1);
`ifdef SERIAL_TXQ_OVF_CNT_EN
    check("t2_ovf", 32'(bus.ovfCnt), 32'd1);
`endif
    ack("t2_a5_done");
    for (int i = 0; i < 16; i++) serve(8'(i), "t2_order");
    n = 0;
    repeat (40) begin
      tick();
      if (bus.transEnable) n++;
    end
    check("t2_no_ff", 32'(n), 32'd0);
    check("t2_empty_end", 32'(bus.empty), 32'd1);

    // Write coinciding with pop at count 5; 40 bytes across pointer wrap.
    nw = 0;
    for (int i = 0; i < 6; i++) begin
      b = 8'h80 + 8'(nw);
      q.push_back(b);
      wr(b);
      nw++;
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      wait_te(1'b1, "t3_te");
      check("t3_order", 32'(bus.dataToSent), 32'(e));
      ack("t3_done");
      if (nw < 40) begin
        b = 8'h80 + 8'(nw);
        q.push_back(b);
        wr(b);
        nw++;
        check("t3_count5", 32'(bus.count), 32'd5);
      end
    end
    check("t3_empty", 32'(bus.empty), 32'd1);

    // No charSent: timeout then next byte goes normally.
    wr(8'hC1);
    wr(8'hC2);
    wait_te(1'b1, "t4_te");
    check("t4_data", 32'(bus.dataToSent), 32'hC1);
    wait_te(1'b0, "t4_te_low");
    n = 0;
    while (!bus.txErr && n < 5000) begin
      tick();
      n++;
    end
    check("t4_timeout", 32'(n), 32'(TIMEOUT));
    serve(8'hC2, "t4_next");
    check("t4_sticky", 32'(bus.txErr), 32'd1);

    // charSent held high: no edge, so timeout; a fresh edge completes.
    wr(8'hD1);
    wr(8'hD2);
    wait_te(1'b1, "t6_te1");
    check("t6_d1", 32'(bus.dataToSent), 32'hD1);
    wait_te(1'b0, "t6_te1_low");
    bus.charSent = 1'b1;
    wait_idle("t6_d1_done");
    wait_te(1'b1, "t6_te2");
    check("t6_d2", 32'(bus.dataToSent), 32'hD2);
    wait_te(1'b0, "t6_te2_low");
    n = 0;
    while (bus.busy && n < 5000) begin
      tick();
      n++;
    end
    check("t6_held_timeout", 32'(n), 32'(TIMEOUT + 1));
    wr(8'hD3);
    wait_te(1'b1, "t6_te3");
    check("t6_d3", 32'(bus.dataToSent), 32'hD3);
    wait_te(1'b0, "t6_te3_low");
    bus.charSent = 1'b0;
    repeat (3) tick();
    check("t6_still_busy", 32'(bus.busy), 32'd1);
    bus.charSent = 1'b1;
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    check("t6_fresh_edge", 32'(n), 32'd4);
    bus.charSent = 1'b0;

    // Asynchronous reset in the middle of LOAD with 3 queued.
    for (int i = 0; i < 4; i++) wr(8'hE0 + 8'(i));
    wait_te(1'b1, "t5_te");
    repeat (3) tick();
    check("t5_count3", 32'(bus.count), 32'd3);
    rst_n = 1'b0;
    #1;
    check("t5_te_async", 32'(bus.transEnable), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_count", 32'(bus.count), 32'd0);
    check("t5_empty", 32'(bus.empty), 32'd1);
    check("t5_data", 32'(bus.dataToSent), 32'h0);
    check("t5_txerr", 32'(bus.txErr), 32'd0);
`ifdef SERIAL_TXQ_OVF_CNT_EN
    check("t5_ovf", 32'(bus.ovfCnt), 32'd0);
`endif
    #3;
    rst_n = 1'b1;
    n = 0;
    repeat (50) begin
      tick();
      if (bus.transEnable) n++;
    end
    check("t5_no_te", 32'(n), 32'd0);
    check("t5_count_after", 32'(bus.count), 32'd0);
    check("t5_empty_after", 32'(bus.empty), 32'd1);
    check("t5_data_after", 32'(bus.dataToSent), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
